// File: rtl/load_store_unit.sv
// load_store_unit: memory stage between execute and writeback.
//   Holds one instruction in the M register. It decodes size, signedness and alignment from
//   funct3 and the address offset, and drives a req/ack bus that may insert wait states.
//   While a request is unanswered it stalls the earlier stages. After MAX_WAIT wait cycles
//   it aborts the request.
// Ports:
//   clk_i, reset_i (async, active-low)
//   E-stage inputs : valid_e_i, alu_result_e_i, write_data_e_i, rd_e_i, pc_plus_4_e_i,
//                    mem_read_e_i, mem_write_e_i, funct3_e_i
//   Bus            : bus_req_o, bus_addr_o, bus_wr_en_o, bus_be_o, bus_wr_data_o,
//                    bus_ack_i, bus_rd_data_i
//   Pipeline       : stall_m_o, valid_m_o, alu_result_m_o, read_data_m_o, rd_m_o,
//                    pc_plus_4_m_o
//   Exceptions     : misaligned_o, timeout_o
module load_store_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              valid_e_i,
  input  logic [XLEN-1:0]   alu_result_e_i,
  input  logic [XLEN-1:0]   write_data_e_i,
  input  logic [4:0]        rd_e_i,
  input  logic [XLEN-1:0]   pc_plus_4_e_i,
  input  logic              mem_read_e_i,
  input  logic              mem_write_e_i,
  input  logic [2:0]        funct3_e_i,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic              bus_wr_en_o,
  output logic [XLEN/8-1:0] bus_be_o,
  output logic [XLEN-1:0]   bus_wr_data_o,
  input  logic              bus_ack_i,
  input  logic [XLEN-1:0]   bus_rd_data_i,
  output logic              stall_m_o,
  output logic              valid_m_o,
  output logic [XLEN-1:0]   alu_result_m_o,
  output logic [XLEN-1:0]   read_data_m_o,
  output logic [4:0]        rd_m_o,
  output logic [XLEN-1:0]   pc_plus_4_m_o,
  output logic              misaligned_o,
  output logic              timeout_o
);

  localparam int unsigned BeW  = XLEN / 8;
  localparam int unsigned OffW = $clog2(BeW);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  // M register
  logic            r_valid;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_data;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_pc4;
  logic            r_read;
  logic            r_write;
  logic [2:0]      r_funct3;

  state_e          r_state;
  state_e          w_state_d;
  logic [7:0]      r_cnt;
  logic [7:0]      w_cnt_d;

  logic            w_mem_op;
  logic            w_illegal;
  logic            w_misaligned;
  logic            w_req;
  logic            w_abort;
  logic            w_stall;
  int unsigned     w_size_n;
  int unsigned     w_off_n;
  int unsigned     w_top;
  logic            w_sign;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_ext;
  logic [XLEN-1:0] w_wdata;
  logic [BeW-1:0]  w_be;
  logic [ADDR_W-1:0] w_addr;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_valid  <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_rd     <= '0;
      r_pc4    <= '0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_funct3 <= '0;
      r_state  <= StIdle;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (!w_stall) begin
        r_valid  <= valid_e_i;
        r_addr   <= alu_result_e_i;
        r_data   <= write_data_e_i;
        r_rd     <= rd_e_i;
        r_pc4    <= pc_plus_4_e_i;
        r_read   <= valid_e_i & mem_read_e_i;
        r_write  <= valid_e_i & mem_write_e_i;
        r_funct3 <= funct3_e_i;
      end
    end
  end

  // Access decode and handshake control
  always_comb begin
    w_size_n  = 32'd1 << r_funct3[1:0];
    w_off_n   = 32'(r_addr[OffW-1:0]);
    // Doubleword exists only at XLEN=64; 111 is never legal.
    w_illegal = (XLEN == 64) ? (r_funct3 == 3'b111) : (r_funct3[1:0] == 2'b11);
    w_mem_op  = r_valid & (r_read | r_write);
    w_misaligned = w_mem_op & (w_illegal | ((w_off_n & (w_size_n - 32'd1)) != 32'd0));
    w_req     = w_mem_op & ~w_misaligned;
    w_abort   = (r_state == StWait) & w_req & ~bus_ack_i & (r_cnt == 8'(MAX_WAIT));
    w_stall   = w_req & ~bus_ack_i & ~w_abort;
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_req && !bus_ack_i) begin
          w_state_d = StWait;
          w_cnt_d   = 8'd1;
        end
      end
      StWait: begin
        if (!w_req || bus_ack_i || w_abort) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Lane steering: byte enables, replicated store data, extended load data
  always_comb begin
    w_be    = '0;
    w_wdata = '0;
    w_ext   = '0;
    for (int unsigned i = 0; i < BeW; i++) begin
      w_be[i] = (i >= w_off_n) && (i < w_off_n + w_size_n);
      w_wdata[8*i +: 8] = r_data[8*(i & (w_size_n - 32'd1)) +: 8];
    end
    w_lane = bus_rd_data_i >> (8 * w_off_n);
    // Clamp keeps the sign-bit index in range for the illegal 8-byte size at XLEN=32.
    w_top  = (8 * w_size_n > XLEN) ? XLEN - 1 : 8 * w_size_n - 1;
    w_sign = ~r_funct3[2] & w_lane[w_top];
    for (int unsigned i = 0; i < XLEN; i++) begin
      w_ext[i] = (i <= w_top) ? w_lane[i] : w_sign;
    end
    w_addr = r_addr[ADDR_W-1:0];
    w_addr[OffW-1:0] = '0;
  end

  always_comb begin
    bus_req_o      = w_req;
    bus_addr_o     = w_req ? w_addr : '0;
    bus_wr_en_o    = w_req & r_write;
    bus_be_o       = w_req ? w_be : '0;
    bus_wr_data_o  = w_req ? w_wdata : '0;
    stall_m_o      = w_stall;
    valid_m_o      = r_valid & ~w_stall;
    alu_result_m_o = r_addr;
    pc_plus_4_m_o  = r_pc4;
    // Read-and-write together behaves as a store, so no load data.
    read_data_m_o  = (w_req & r_read & ~r_write & bus_ack_i) ? w_ext : '0;
    rd_m_o         = (w_misaligned | w_abort) ? 5'd0 : r_rd;
    misaligned_o   = w_misaligned;
    timeout_o      = w_abort;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        valid_e_i;
  logic [31:0] alu_result_e_i, write_data_e_i, pc_plus_4_e_i;
  logic [4:0]  rd_e_i;
  logic        mem_read_e_i, mem_write_e_i;
  logic [2:0]  funct3_e_i;
  logic        bus_req_o, bus_wr_en_o, bus_ack_i;
  logic [31:0] bus_addr_o, bus_wr_data_o, bus_rd_data_i;
  logic [3:0]  bus_be_o;
  logic        stall_m_o, valid_m_o, misaligned_o, timeout_o;
  logic [31:0] alu_result_m_o, read_data_m_o, pc_plus_4_m_o;
  logic [4:0]  rd_m_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(MW)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_e_i(valid_e_i), .alu_result_e_i(alu_result_e_i),
    .write_data_e_i(write_data_e_i), .rd_e_i(rd_e_i), .pc_plus_4_e_i(pc_plus_4_e_i),
    .mem_read_e_i(mem_read_e_i), .mem_write_e_i(mem_write_e_i), .funct3_e_i(funct3_e_i),
    .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_wr_en_o(bus_wr_en_o),
    .bus_be_o(bus_be_o), .bus_wr_data_o(bus_wr_data_o), .bus_ack_i(bus_ack_i),
    .bus_rd_data_i(bus_rd_data_i), .stall_m_o(stall_m_o), .valid_m_o(valid_m_o),
    .alu_result_m_o(alu_result_m_o), .read_data_m_o(read_data_m_o), .rd_m_o(rd_m_o),
    .pc_plus_4_m_o(pc_plus_4_m_o), .misaligned_o(misaligned_o), .timeout_o(timeout_o)
  );

  typedef struct {
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    logic [4:0]  rd;
    int          wait_n;   // ack arrives in this M cycle (large = never)
    logic        e_req;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_mis;
    int          e_stall;
    logic        e_tmo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(logic rd_en, logic wr_en, logic [2:0] f3, logic [31:0] addr,
                               logic [31:0] wdata, logic [31:0] brd, logic [4:0] rd,
                               int wait_n, logic e_req, logic [3:0] e_be,
                               logic [31:0] e_wdata, logic [31:0] e_rdata, logic e_mis,
                               int e_stall, logic e_tmo);
    vec_t v;
    v.rd_en = rd_en; v.wr_en = wr_en; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.bus_rdata = brd; v.rd = rd; v.wait_n = wait_n; v.e_req = e_req; v.e_be = e_be;
    v.e_wdata = e_wdata; v.e_rdata = e_rdata; v.e_mis = e_mis; v.e_stall = e_stall;
    v.e_tmo = e_tmo;
    return v;
  endfunction

  // Reference model: expected bus/pipeline behaviour from plain arithmetic on the access rules.
  function automatic vec_t model(logic rd_en, logic wr_en, logic [2:0] f3, logic [31:0] addr,
                                 logic [31:0] wdata, logic [31:0] brd, logic [4:0] rd,
                                 int wait_n);
    vec_t   v;
    int     size, off;
    longint lane;
    logic   mem, aligned;
    size = 1 << (f3 % 4);
    off  = int'(addr % 4);
    mem  = rd_en || wr_en;
    aligned = (f3 % 4 != 3) && (off % size == 0);
    v = mkv(rd_en, wr_en, f3, addr, wdata, brd, rd, wait_n, 0, 0, 0, 0, 0, 0, 0);
    v.e_req = mem && aligned;
    v.e_mis = mem && !aligned;
    if (v.e_req) v.e_be = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++)
      v.e_wdata = v.e_wdata | (((wdata >> (8 * (i % size))) & 32'hFF) << (8 * i));
    v.e_stall = v.e_req ? ((wait_n < MW) ? wait_n : MW) : 0;
    v.e_tmo   = v.e_req && (wait_n > MW);
    if (v.e_req && rd_en && !wr_en && !v.e_tmo) begin
      lane = longint'(brd) >> (8 * off);
      lane = lane % (64'sd1 << (8 * size));
      if (f3 < 4 && lane >= (64'sd1 << (8 * size - 1))) lane = lane - (64'sd1 << (8 * size));
      v.e_rdata = lane[31:0];
    end
    return v;
  endfunction

  task automatic bubble();
    valid_e_i = 1'b0; mem_read_e_i = 1'b0; mem_write_e_i = 1'b0;
    alu_result_e_i = $urandom; write_data_e_i = $urandom; rd_e_i = 5'(($urandom % 32));
    pc_plus_4_e_i = $urandom; funct3_e_i = 3'(($urandom % 8));
  endtask

  task automatic apply(input vec_t v, input string tag);
    valid_e_i = 1'b1; alu_result_e_i = v.addr; write_data_e_i = v.wdata; rd_e_i = v.rd;
    pc_plus_4_e_i = v.addr + 32'd4; mem_read_e_i = v.rd_en; mem_write_e_i = v.wr_en;
    funct3_e_i = v.f3; bus_ack_i = 1'b0;
    @(posedge clk); #1;
    bubble();
    for (int k = 0; k <= v.e_stall; k++) begin
      bus_ack_i = (k == v.wait_n) || (!v.e_req && ($urandom % 2 == 1));
      bus_rd_data_i = v.bus_rdata;
      #1;
      check({tag, ".req"}, bus_req_o, v.e_req);
      check({tag, ".wr_en"}, bus_wr_en_o, v.e_req && v.wr_en);
      if (v.e_req) begin
        check({tag, ".addr"}, bus_addr_o, {v.addr[31:2], 2'b00});
        check({tag, ".be"}, bus_be_o, v.e_be);
        if (v.wr_en) check({tag, ".wdata"}, bus_wr_data_o, v.e_wdata);
      end
      check({tag, ".stall"}, stall_m_o, k < v.e_stall);
      check({tag, ".valid"}, valid_m_o, k == v.e_stall);
      check({tag, ".mis"}, misaligned_o, v.e_mis);
      check({tag, ".tmo"}, timeout_o, v.e_tmo && k == v.e_stall);
      if (k == v.e_stall) begin
        check({tag, ".rd"}, rd_m_o, (v.e_mis || v.e_tmo) ? 5'd0 : v.rd);
        check({tag, ".rdata"}, read_data_m_o, v.e_rdata);
        check({tag, ".alu"}, alu_result_m_o, v.addr);
        check({tag, ".pc4"}, pc_plus_4_m_o, v.addr + 32'd4);
      end
      @(posedge clk); #1;
    end
    bus_ack_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req"}, bus_req_o, 0);
    check({tag, ".addr"}, bus_addr_o, 0);
    check({tag, ".be"}, bus_be_o, 0);
    check({tag, ".wr_en"}, bus_wr_en_o, 0);
    check({tag, ".wdata"}, bus_wr_data_o, 0);
    check({tag, ".stall"}, stall_m_o, 0);
    check({tag, ".valid"}, valid_m_o, 0);
    check({tag, ".alu"}, alu_result_m_o, 0);
    check({tag, ".rdata"}, read_data_m_o, 0);
    check({tag, ".rd"}, rd_m_o, 0);
    check({tag, ".pc4"}, pc_plus_4_m_o, 0);
    check({tag, ".mis"}, misaligned_o, 0);
    check({tag, ".tmo"}, timeout_o, 0);
  endtask

  vec_t tbl[15];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // Table: rd, wr, f3, addr, wdata, bus_rdata, rd, wait | req, be, wdata, rdata, mis, stall, tmo
    tbl[0]  = mkv(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 5'd1, 0,
                  1, 4'hF, 0, 32'hDEADBEEF, 0, 0, 0);
    tbl[1]  = mkv(1, 0, 3'b000, 32'h103, 0, 32'h80FF0000, 5'd2, 0,
                  1, 4'h8, 0, 32'hFFFFFF80, 0, 0, 0);
    tbl[2]  = mkv(1, 0, 3'b100, 32'h103, 0, 32'h80FF0000, 5'd3, 0,
                  1, 4'h8, 0, 32'h00000080, 0, 0, 0);
    tbl[3]  = mkv(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 0, 5'd4, 3,
                  1, 4'hC, 32'hABCDABCD, 0, 0, 3, 0);
    tbl[4]  = mkv(1, 0, 3'b010, 32'h101, 0, 32'h11111111, 5'd5, 0,
                  0, 4'h0, 0, 0, 1, 0, 0);
    tbl[5]  = mkv(1, 0, 3'b010, 32'h200, 0, 32'h22222222, 5'd6, 99,
                  1, 4'hF, 0, 0, 0, MW, 1);
    tbl[6]  = mkv(1, 0, 3'b001, 32'h106, 0, 32'h80010000, 5'd7, 1,
                  1, 4'hC, 0, 32'hFFFF8001, 0, 1, 0);
    tbl[7]  = mkv(1, 0, 3'b101, 32'h102, 0, 32'h80011234, 5'd8, 2,
                  1, 4'hC, 0, 32'h00008001, 0, 2, 0);
    tbl[8]  = mkv(0, 1, 3'b000, 32'h101, 32'h0000005A, 0, 5'd9, 0,
                  1, 4'h2, 32'h5A5A5A5A, 0, 0, 0, 0);
    tbl[9]  = mkv(0, 1, 3'b010, 32'h10C, 32'hCAFEF00D, 0, 5'd10, MW,
                  1, 4'hF, 32'hCAFEF00D, 0, 0, MW, 0);
    tbl[10] = mkv(1, 0, 3'b001, 32'h103, 0, 32'h33333333, 5'd11, 0,
                  0, 4'h0, 0, 0, 1, 0, 0);
    tbl[11] = mkv(1, 0, 3'b011, 32'h100, 0, 32'h44444444, 5'd12, 0,
                  0, 4'h0, 0, 0, 1, 0, 0);
    tbl[12] = mkv(0, 0, 3'b011, 32'h101, 0, 32'h55555555, 5'd13, 0,
                  0, 4'h0, 0, 0, 0, 0, 0);
    tbl[13] = mkv(1, 1, 3'b010, 32'h104, 32'h11223344, 32'h66666666, 5'd14, 0,
                  1, 4'hF, 32'h11223344, 0, 0, 0, 0);
    tbl[14] = mkv(1, 0, 3'b110, 32'h108, 0, 32'h89ABCDEF, 5'd15, 0,
                  1, 4'hF, 0, 32'h89ABCDEF, 0, 0, 0);

    // Reset with a live memory op presented: everything must stay 0.
    reset_i = 1'b0; bus_ack_i = 1'b1; bus_rd_data_i = 32'hFFFFFFFF;
    valid_e_i = 1'b1; mem_read_e_i = 1'b1; mem_write_e_i = 1'b0; funct3_e_i = 3'b010;
    alu_result_e_i = 32'h104; write_data_e_i = 32'h1; rd_e_i = 5'd1; pc_plus_4_e_i = 32'h108;
    #12;
    check_all_zero("reset");
    bubble(); bus_ack_i = 1'b0;
    #5 reset_i = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

    // Back-to-back: store request issued in the cycle right after the load's ack.
    valid_e_i = 1'b1; mem_read_e_i = 1'b1; mem_write_e_i = 1'b0; funct3_e_i = 3'b010;
    alu_result_e_i = 32'h400; rd_e_i = 5'd3; pc_plus_4_e_i = 32'h404;
    @(posedge clk); #1;
    mem_read_e_i = 1'b0; mem_write_e_i = 1'b1; alu_result_e_i = 32'h404;
    write_data_e_i = 32'h77; rd_e_i = 5'd0;
    bus_ack_i = 1'b1; bus_rd_data_i = 32'h12345678; #1;
    check("b2b.ld_valid", valid_m_o, 1);
    check("b2b.ld_rdata", read_data_m_o, 32'h12345678);
    @(posedge clk); #1;
    bubble(); #1;
    check("b2b.st_req", bus_req_o, 1);
    check("b2b.st_addr", bus_addr_o, 32'h404);
    check("b2b.st_wr_en", bus_wr_en_o, 1);
    check("b2b.st_wdata", bus_wr_data_o, 32'h77);
    check("b2b.st_valid", valid_m_o, 1);
    @(posedge clk); #1;
    bus_ack_i = 1'b0; #1;
    check("b2b.idle_req", bus_req_o, 0);

    // Reset mid-WAIT drops the request at once; a fresh load then completes normally.
    valid_e_i = 1'b1; mem_read_e_i = 1'b1; mem_write_e_i = 1'b0; funct3_e_i = 3'b010;
    alu_result_e_i = 32'h300; rd_e_i = 5'd7; pc_plus_4_e_i = 32'h304;
    @(posedge clk); #1;
    bubble(); bus_ack_i = 1'b0;
    @(posedge clk); #1;
    check("rstwait.stall", stall_m_o, 1);
    check("rstwait.req", bus_req_o, 1);
    reset_i = 1'b0; #1;
    check_all_zero("rstwait");
    #2 reset_i = 1'b1;
    @(posedge clk); #1;
    apply(mkv(1, 0, 3'b010, 32'h500, 0, 32'hA5A55A5A, 5'd9, 1,
              1, 4'hF, 0, 32'hA5A55A5A, 0, 1, 0), "post_rst");

    // Randomised traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      logic rd_en, wr_en;
      int   sel;
      sel = int'($urandom % 8);
      rd_en = (sel < 4) || (sel == 7);
      wr_en = (sel >= 4);
      if (sel == 6) begin rd_en = 1'b0; wr_en = 1'b0; end
      v = model(rd_en, wr_en, 3'(($urandom % 8)), 32'h1000 + ($urandom % 64), $urandom,
                $urandom, 5'(($urandom % 32)), int'($urandom % 7));
      apply(v, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
